// File: rtl/pipe_stage_chain.sv
// Stepped in-order pipeline of NUM_STAGES registers with per-stage stall/flush, sticky halt and saturating stats.
// One adv edge per stage; a stall freezes its stage and everything upstream, inserting a bubble just below it.
module pipe_stage_chain #(
    parameter int NB         = 32,
    parameter int NUM_STAGES = 5,
    parameter int CNT_NB     = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_step,
    input  logic                       i_in_valid,
    input  logic [NB-1:0]              i_in_data,
    input  logic                       i_in_halt,
    input  logic [NUM_STAGES-1:0]      i_stall,
    input  logic [NUM_STAGES-1:0]      i_flush,
    output logic                       o_in_ready,
    output logic [NUM_STAGES-1:0]      o_valid,
    output logic [NUM_STAGES*NB-1:0]   o_data,
    output logic [NUM_STAGES-1:0]      o_halt_flags,
    output logic                       o_out_valid,
    output logic [NB-1:0]              o_out_data,
    output logic                       o_halted,
    output logic [CNT_NB-1:0]          o_cycle_count,
    output logic [CNT_NB-1:0]          o_retired_count,
    output logic [CNT_NB-1:0]          o_bubble_count
);

    localparam int LAST = NUM_STAGES - 1;
    localparam logic [CNT_NB-1:0] CNT_ONE = {{(CNT_NB-1){1'b0}}, 1'b1};

    logic [NUM_STAGES-1:0]    valid_q, valid_d;
    logic [NUM_STAGES-1:0]    halt_q, halt_d;
    logic [NUM_STAGES*NB-1:0] data_q, data_d;
    logic                     halted_q, halted_d;
    logic [CNT_NB-1:0]        cycle_q, cycle_d;
    logic [CNT_NB-1:0]        retired_q, retired_d;
    logic [CNT_NB-1:0]        bubble_q, bubble_d;

    logic                     adv;
    logic [NUM_STAGES-1:0]    hold;
    logic [NUM_STAGES-1:0]    prev_hold;
    logic [NUM_STAGES-1:0]    src_valid;
    logic [NUM_STAGES-1:0]    src_halt;
    logic [NUM_STAGES*NB-1:0] src_data;
    logic [NB-1:0]            in_data_m;
    logic                     retire;
    logic                     bubble_exit;

    assign adv = i_step & ~halted_q;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_hold
        assign hold[k] = |i_stall[NUM_STAGES-1:k];
    end

    // Each stage's upstream source, with the chain inputs acting as stage -1.
    assign in_data_m = i_in_valid ? i_in_data : '0;
    assign prev_hold = {hold[NUM_STAGES-2:0], 1'b0};
    assign src_valid = {valid_q[NUM_STAGES-2:0], i_in_valid};
    assign src_halt  = {halt_q[NUM_STAGES-2:0], i_in_valid & i_in_halt};
    assign src_data  = {data_q[(NUM_STAGES-1)*NB-1:0], in_data_m};

    assign retire      = adv &  valid_q[LAST] & ~hold[LAST];
    assign bubble_exit = adv & ~valid_q[LAST] & ~hold[LAST];

    always_comb begin
        valid_d   = valid_q;
        halt_d    = halt_q;
        data_d    = data_q;
        halted_d  = halted_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (adv) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (i_flush[k] || (!hold[k] && prev_hold[k])) begin
                    valid_d[k]          = 1'b0;
                    halt_d[k]           = 1'b0;
                    data_d[k*NB +: NB]  = '0;
                end else if (!hold[k]) begin
                    valid_d[k]          = src_valid[k];
                    halt_d[k]           = src_halt[k];
                    data_d[k*NB +: NB]  = src_data[k*NB +: NB];
                end
            end
            halted_d = halted_q | (retire & halt_q[LAST]);
            if (!(&cycle_q)) begin
                cycle_d = cycle_q + CNT_ONE;
            end
            if (retire && !(&retired_q)) begin
                retired_d = retired_q + CNT_ONE;
            end
            if (bubble_exit && !(&bubble_q)) begin
                bubble_d = bubble_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid_q   <= '0;
            halt_q    <= '0;
            data_q    <= '0;
            halted_q  <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            halt_q    <= halt_d;
            data_q    <= data_d;
            halted_q  <= halted_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign o_in_ready      = i_reset & adv & ~hold[0] & ~i_flush[0];
    assign o_valid         = valid_q;
    assign o_data          = data_q;
    assign o_halt_flags    = halt_q;
    assign o_out_valid     = valid_q[LAST];
    assign o_out_data      = data_q[LAST*NB +: NB];
    assign o_halted        = halted_q;
    assign o_cycle_count   = cycle_q;
    assign o_retired_count = retired_q;
    assign o_bubble_count  = bubble_q;

endmodule
